// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and types for the stream_mux_arb multiplexer.
package stream_mux_arb_pkg;

    // Arbitration mode encoding for the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Arbiter FSM: ARB picks a new source, LOCK stays on one channel until last.
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Circular increment of a channel index within [0, n-1].
    function automatic int wrap_inc(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_pick.sv
// Combinational rotating-priority picker: the first requester at or after
// ptr (wrapping at NUM_CH-1) wins.
module rr_pick #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % NUM_CH;
            if (req[c]) begin
                any = 1'b1;
                idx = SEL_W'(c);
            end else begin
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with fixed/round-robin arbitration, packet
// locking on in_last, and a registered, back-pressurable output stage.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    state_t              state_r, state_nx_s;
    logic [SEL_W-1:0]    rr_ptr_r, rr_ptr_nx_s;
    logic [SEL_W-1:0]    lock_ch_r, lock_ch_nx_s;

    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_last_r;
    logic [SEL_W-1:0]    out_ch_r;

    logic                free_s;
    logic                accept_s;
    logic                sel_ok_s;
    logic [NUM_CH-1:0]   grant_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic                grant_any_s;
    logic [NUM_CH-1:0]   rr_grant_s;
    logic [SEL_W-1:0]    rr_idx_s;
    logic                rr_any_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                sel_last_s;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req    (in_valid),
        .ptr    (rr_ptr_r),
        .grant  (rr_grant_s),
        .idx    (rr_idx_s),
        .any    (rr_any_s)
    );

    // The output slot can take a beat when empty or when it is draining now.
    assign free_s   = !out_valid_r || out_ready;
    // A sel beyond the channel count never grants (matters when NUM_CH is not a power of two).
    assign sel_ok_s = (32'(sel) < 32'(NUM_CH));

    // Source selection: locked channel, fixed sel, or round-robin pick.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        case (state_r)
            ST_ARB: begin
                if (mode == MODE_RR) begin
                    grant_s     = rr_grant_s;
                    grant_idx_s = rr_idx_s;
                    grant_any_s = rr_any_s;
                end else begin
                    grant_idx_s = sel;
                    grant_any_s = sel_ok_s && in_valid[sel];
                    if (grant_any_s) begin
                        grant_s[sel] = 1'b1;
                    end else begin
                        grant_s = '0;
                    end
                end
            end
            ST_LOCK: begin
                grant_idx_s = lock_ch_r;
                grant_any_s = in_valid[lock_ch_r];
                if (grant_any_s) begin
                    grant_s[lock_ch_r] = 1'b1;
                end else begin
                    grant_s = '0;
                end
            end
            default: begin
                grant_s     = '0;
                grant_idx_s = '0;
                grant_any_s = 1'b0;
            end
        endcase
    end

    assign sel_data_s = in_data[int'(grant_idx_s) * DATA_W +: DATA_W];
    assign sel_last_s = in_last[grant_idx_s];
    assign accept_s   = free_s && grant_any_s;
    assign in_ready   = rst_n ? (grant_s & {NUM_CH{free_s}}) : '0;

    // Next FSM state, round-robin pointer and lock channel from the accepted beat.
    always_comb begin
        state_nx_s   = state_r;
        rr_ptr_nx_s  = rr_ptr_r;
        lock_ch_nx_s = lock_ch_r;
        if (accept_s) begin
            if (sel_last_s) begin
                state_nx_s  = ST_ARB;
                rr_ptr_nx_s = SEL_W'(wrap_inc(int'(grant_idx_s), NUM_CH));
            end else begin
                state_nx_s   = ST_LOCK;
                lock_ch_nx_s = grant_idx_s;
            end
        end else begin
            state_nx_s   = state_r;
            rr_ptr_nx_s  = rr_ptr_r;
            lock_ch_nx_s = lock_ch_r;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_ARB;
            rr_ptr_r  <= '0;
            lock_ch_r <= '0;
        end else begin
            state_r   <= state_nx_s;
            rr_ptr_r  <= rr_ptr_nx_s;
            lock_ch_r <= lock_ch_nx_s;
        end
    end

    // Output stage: load on accept, empty when free with nothing granted, hold on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_ch_r    <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_last_r  <= sel_last_s;
            out_ch_r    <= grant_idx_s;
        end else if (free_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: directed vector table followed by
// randomized traffic compared against a behavioural reference model.
module tb_stream_mux_arb;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_last;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_ready;

    int checks = 0;
    int errors = 0;

    stream_mux_arb #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    // Free-running clock.
    initial begin
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] valid;
        logic [7:0] last;
        logic       ordy;
        logic [7:0] exp_ir;
        logic       exp_ov;
        logic [2:0] exp_ch;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic md, input logic [2:0] s,
                       input logic [7:0] v, input logic [7:0] l, input logic ordy,
                       input logic [7:0] ir, input logic ov, input logic [2:0] ch,
                       input logic [7:0] d, input logic lst);
        vec_t t;
        t.rst = rst; t.mode = md; t.sel = s; t.valid = v; t.last = l; t.ordy = ordy;
        t.exp_ir = ir; t.exp_ov = ov; t.exp_ch = ch; t.exp_data = d; t.exp_last = lst;
        tbl.push_back(t);
    endtask

    // ---------------- reference model ----------------
    bit         m_valid;
    logic [7:0] m_data;
    bit         m_last;
    int         m_ch;
    bit         m_locked;
    int         m_lock_ch;
    int         m_ptr;

    // Channel that wins this cycle, or -1: locked channel, fixed sel, or the
    // valid channel with the smallest circular distance from the pointer.
    function automatic int model_grant();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NUM_CH;
        if (m_locked) begin
            best = in_valid[m_lock_ch] ? m_lock_ch : -1;
        end else if (mode == 1'b0) begin
            best = (int'(sel) < NUM_CH && in_valid[sel]) ? int'(sel) : -1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                d = (i - m_ptr + NUM_CH) % NUM_CH;
                if (in_valid[i] && d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    initial begin
        int  g;
        bit  free;
        logic [7:0] exp_ir;

        // rst mode sel valid last ordy | in_ready ov ch data last
        for (int r = 0; r < 3; r++) add(1'b0, 1'b0, 3'd5, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 3'd5, 8'hFF, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 8'h15, 1'b1);
        add(1'b1, 1'b0, 3'd5, 8'hFF, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 8'h15, 1'b1);
        add(1'b1, 1'b0, 3'd7, 8'h7F, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd5, 8'h15, 1'b1);
        add(1'b1, 1'b1, 3'd7, 8'hFF, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, 8'h16, 1'b1);
        add(1'b1, 1'b1, 3'd7, 8'hFF, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 8'h17, 1'b1);
        add(1'b1, 1'b1, 3'd7, 8'hFF, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10, 1'b1);
        for (int r = 0; r < 4; r++) add(1'b1, 1'b1, 3'd7, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd0, 8'h10, 1'b1);
        add(1'b1, 1'b1, 3'd7, 8'hFF, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11, 1'b1);
        add(1'b1, 1'b1, 3'd7, 8'h84, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 8'h12, 1'b1);
        add(1'b1, 1'b1, 3'd7, 8'h84, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 8'h17, 1'b1);
        add(1'b1, 1'b1, 3'd7, 8'h84, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 8'h12, 1'b1);
        add(1'b1, 1'b1, 3'd7, 8'h84, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 8'h17, 1'b1);
        add(1'b1, 1'b1, 3'd0, 8'h18, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3, 8'h13, 1'b0);
        add(1'b1, 1'b0, 3'd4, 8'h18, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3, 8'h13, 1'b0);
        add(1'b1, 1'b1, 3'd0, 8'h18, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 8'h13, 1'b1);
        add(1'b1, 1'b1, 3'd0, 8'h10, 8'h10, 1'b1, 8'h10, 1'b1, 3'd4, 8'h14, 1'b1);
        add(1'b1, 1'b1, 3'd0, 8'h06, 8'h00, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11, 1'b0);
        add(1'b1, 1'b1, 3'd0, 8'h04, 8'h00, 1'b1, 8'h00, 1'b0, 3'd1, 8'h11, 1'b0);
        add(1'b1, 1'b1, 3'd0, 8'h06, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11, 1'b1);
        add(1'b1, 1'b1, 3'd0, 8'h08, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3, 8'h13, 1'b0);
        add(1'b1, 1'b1, 3'd0, 8'h08, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3, 8'h13, 1'b0);
        add(1'b0, 1'b1, 3'd0, 8'h08, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        add(1'b1, 1'b1, 3'd0, 8'h09, 8'h09, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10, 1'b1);

        for (int i = 0; i < NUM_CH; i++) in_data[i*DATA_W +: DATA_W] = 8'h10 + 8'(i);

        for (int n = 0; n < tbl.size(); n++) begin
            rst_n     = tbl[n].rst;
            mode      = tbl[n].mode;
            sel       = tbl[n].sel;
            in_valid  = tbl[n].valid;
            in_last   = tbl[n].last;
            out_ready = tbl[n].ordy;
            #1;
            check($sformatf("t%0d_in_ready", n), 32'(in_ready), 32'(tbl[n].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("t%0d_out_valid", n), 32'(out_valid), 32'(tbl[n].exp_ov));
            check($sformatf("t%0d_out_ch", n), 32'(out_ch), 32'(tbl[n].exp_ch));
            check($sformatf("t%0d_out_data", n), 32'(out_data), 32'(tbl[n].exp_data));
            check($sformatf("t%0d_out_last", n), 32'(out_last), 32'(tbl[n].exp_last));
        end

        // ---------------- randomized traffic vs model ----------------
        for (int n = 0; n < 600; n++) begin
            rst_n     = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
            sel       = 3'($urandom_range(0, 7));
            in_valid  = 8'($urandom);
            in_last   = 8'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            #1;
            g      = model_grant();
            free   = !m_valid || out_ready;
            exp_ir = (rst_n && free && g >= 0) ? 8'(1 << g) : 8'h00;
            check("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
            @(posedge clk);
            if (!rst_n) begin
                m_valid = 1'b0; m_data = 8'h00; m_last = 1'b0; m_ch = 0;
                m_locked = 1'b0; m_lock_ch = 0; m_ptr = 0;
            end else if (free && g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*DATA_W +: DATA_W];
                m_last  = in_last[g];
                m_ch    = g;
                if (in_last[g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % NUM_CH;
                end else begin
                    m_locked  = 1'b1;
                    m_lock_ch = g;
                end
            end else if (free) begin
                m_valid = 1'b0;
            end
            #1;
            check("rnd_out_valid", 32'(out_valid), 32'(m_valid));
            check("rnd_out_data", 32'(out_data), 32'(m_data));
            check("rnd_out_last", 32'(out_last), 32'(m_last));
            check("rnd_out_ch", 32'(out_ch), 32'(m_ch));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
